// File: rtl/uart_tx_stream.sv
// FIFO-buffered UART transmitter, LSB-first, configurable width/stop bits.
// Optional parity (parity_mode port and PARITY state) with UART_TX_PARITY_EN.
module uart_tx_stream #(
    parameter int CLK_DIV    = 5,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 128,
    parameter int STOP_BITS  = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [DATA_BITS-1:0]        wr_data,
    output logic                        ready,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] level,
`ifdef UART_TX_PARITY_EN
    input  logic [1:0]                  parity_mode,
`endif
    output logic                        busy,
    output logic                        o_txp,
    output logic                        tx_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLK_DIV);
    localparam int CW = $clog2(DATA_BITS);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic [DATA_BITS-1:0] shifter;
    logic [BW-1:0]        baud;
    logic [CW-1:0]        bit_cnt;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 baud_last;
    logic                 bit_last;
    logic                 stop_last;
    logic                 line_bit;
`ifdef UART_TX_PARITY_EN
    logic                 par_en;
    logic                 par_bit;
`endif

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign ready = !full;
    assign level = wr_ptr - rd_ptr;
    assign push  = wr_en && ready;
    assign head  = mem[rd_ptr[AW-1:0]];

    assign baud_last = (baud == BW'(CLK_DIV - 1));
    assign bit_last  = (bit_cnt == CW'(DATA_BITS - 1));
    assign stop_last = (bit_cnt == CW'(STOP_BITS - 1));

    // Popping at the last stop cycle chains frames with no idle gap.
    assign pop = !empty &&
                 ((state == IDLE) ||
                  ((state == STOP) && baud_last && stop_last));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && !ready;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_comb begin
        line_bit = 1'b1;
        unique case (state)
            START:   line_bit = 1'b0;
            DATA:    line_bit = shifter[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  line_bit = par_bit;
`endif
            default: line_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            shifter <= '0;
            baud    <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            o_txp   <= 1'b1;
            tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en  <= 1'b0;
            par_bit <= 1'b0;
`endif
        end else begin
            o_txp   <= line_bit;
            tx_done <= (state == STOP) && baud_last && stop_last;
            if (pop) begin
                shifter <= head;
`ifdef UART_TX_PARITY_EN
                par_en  <= (parity_mode == 2'b01) ||
                           (parity_mode == 2'b10);
                par_bit <= (^head) ^ (parity_mode == 2'b10);
`endif
            end
            unique case (state)
                IDLE: begin
                    baud    <= '0;
                    bit_cnt <= '0;
                    if (pop) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        state   <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud    <= '0;
                        shifter <= {1'b0, shifter[DATA_BITS-1:1]};
                        if (bit_last) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= par_en ? PARITY : STOP;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_last) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        state   <= STOP;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (stop_last) begin
                            bit_cnt <= '0;
                            if (pop) begin
                                state <= START;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream: two builds (8N1 depth 4, 5N2 depth 4).
// Parity steps are included when UART_TX_PARITY_EN is defined.
module tb_uart_tx_stream;

    logic       clk;
    logic       rst_n;
    logic       wr0;
    logic [7:0] wd0;
    logic       rdy0;
    logic       ovf0;
    logic [2:0] lvl0;
    logic       busy0;
    logic       tx0;
    logic       done0;
    logic       wr1;
    logic [4:0] wd1;
    logic       rdy1;
    logic       ovf1;
    logic [2:0] lvl1;
    logic       busy1;
    logic       tx1;
    logic       done1;
`ifdef UART_TX_PARITY_EN
    logic [1:0] pm0;
    logic [1:0] pm1;
`endif

    int errors = 0;
    int checks = 0;

    uart_tx_stream #(
        .CLK_DIV(4), .DATA_BITS(8), .FIFO_DEPTH(4), .STOP_BITS(1)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr0), .wr_data(wd0),
        .ready(rdy0), .overflow(ovf0), .level(lvl0),
`ifdef UART_TX_PARITY_EN
        .parity_mode(pm0),
`endif
        .busy(busy0), .o_txp(tx0), .tx_done(done0)
    );

    uart_tx_stream #(
        .CLK_DIV(4), .DATA_BITS(5), .FIFO_DEPTH(4), .STOP_BITS(2)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr1), .wr_data(wd1),
        .ready(rdy1), .overflow(ovf1), .level(lvl1),
`ifdef UART_TX_PARITY_EN
        .parity_mode(pm1),
`endif
        .busy(busy1), .o_txp(tx1), .tx_done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge showing the first start-bit cycle; checks
    // line and tx_done every cycle, returns on the last stop cycle.
    task automatic check_frame(input bit sel, input logic [11:0] fr,
                               input int nb, input string tag);
        logic [1:0] obs;
        logic [1:0] exp;
        for (int k = 0; k < nb * 4; k++) begin
            if (k > 0) @(negedge clk);
            obs = sel ? {tx1, done1} : {tx0, done0};
            exp = {fr[k/4], (k == nb * 4 - 1)};
            chk($sformatf("%s_c%0d", tag, k), 32'(obs), 32'(exp));
        end
    endtask

    initial begin
        int cnt;
        int lows;
        int lv [6] = '{1, 1, 2, 3, 4, 4};
        rst_n = 1'b0;
        wr0 = 1'b0; wd0 = '0;
        wr1 = 1'b0; wd1 = '0;
`ifdef UART_TX_PARITY_EN
        pm0 = 2'b00; pm1 = 2'b00;
`endif
        repeat (3) @(negedge clk);
        chk("rst_txp",   32'(tx0),   32'd1);
        chk("rst_ready", 32'(rdy0),  32'd1);
        chk("rst_busy",  32'(busy0), 32'd0);
        chk("rst_level", 32'(lvl0),  32'd0);
        chk("rst_ovf",   32'(ovf0),  32'd0);
        chk("rst_done",  32'(done0), 32'd0);
        chk("rst_txp1",  32'(tx1),   32'd1);
        chk("rst_rdy1",  32'(rdy1),  32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single 0xA5 frame, start bit low two edges after the write.
        wr0 = 1'b1; wd0 = 8'hA5;
        @(negedge clk);
        wr0 = 1'b0;
        chk("a5_lvl_e0",  32'(lvl0),  32'd1);
        chk("a5_busy_e0", 32'(busy0), 32'd0);
        chk("a5_txp_e0",  32'(tx0),   32'd1);
        @(negedge clk);
        chk("a5_lvl_e1",  32'(lvl0),  32'd0);
        chk("a5_busy_e1", 32'(busy0), 32'd1);
        chk("a5_txp_e1",  32'(tx0),   32'd1);
        @(negedge clk);
        check_frame(1'b0, {2'b0, 1'b1, 8'hA5, 1'b0}, 10, "a5");
        @(negedge clk);
        chk("a5_idle_txp",  32'(tx0),   32'd1);
        chk("a5_idle_busy", 32'(busy0), 32'd0);
        chk("a5_idle_done", 32'(done0), 32'd0);

        // Three back-to-back frames.
        wr0 = 1'b1; wd0 = 8'h01;
        @(negedge clk);
        chk("b2b_lvl_e0", 32'(lvl0), 32'd1);
        wd0 = 8'h02;
        @(negedge clk);
        chk("b2b_lvl_e1", 32'(lvl0), 32'd1);
        wd0 = 8'h03;
        @(negedge clk);
        wr0 = 1'b0;
        chk("b2b_lvl_e2", 32'(lvl0), 32'd2);
        check_frame(1'b0, {2'b0, 1'b1, 8'h01, 1'b0}, 10, "b2b1");
        chk("b2b_lvl_f1", 32'(lvl0), 32'd1);
        @(negedge clk);
        check_frame(1'b0, {2'b0, 1'b1, 8'h02, 1'b0}, 10, "b2b2");
        chk("b2b_lvl_f2", 32'(lvl0), 32'd0);
        @(negedge clk);
        check_frame(1'b0, {2'b0, 1'b1, 8'h03, 1'b0}, 10, "b2b3");
        @(negedge clk);
        chk("b2b_end_busy", 32'(busy0), 32'd0);
        chk("b2b_end_txp",  32'(tx0),   32'd1);

        // Fill past full while transmitting; dropped words pulse overflow.
        wr0 = 1'b1; wd0 = 8'h10;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("ovf_lvl%0d", i), 32'(lvl0), 32'(lv[i]));
            chk($sformatf("ovf_rdy%0d", i), 32'(rdy0), 32'(i < 4));
            chk($sformatf("ovf_ovf%0d", i), 32'(ovf0), 32'(i == 5));
            if (i == 5) wr0 = 1'b0;
            else wd0 = 8'h11 + 8'(i);
        end
        @(negedge clk);
        chk("ovf_pulse_end", 32'(ovf0), 32'd0);
        chk("ovf_lvl_hold",  32'(lvl0), 32'd4);
        wr0 = 1'b1; wd0 = 8'h99;
        @(negedge clk);
        chk("ovf_second", 32'(ovf0), 32'd1);
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (lvl0 != 3'd4) break;
        end
        wr0 = 1'b0;
        chk("ovf_pop_rej_lvl", 32'(lvl0),  32'd3);
        chk("ovf_pop_rej_ovf", 32'(ovf0),  32'd1);
        chk("ovf_pop_done",    32'(done0), 32'd1);
        cnt = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (done0) cnt++;
            if (cnt == 4 && !busy0) break;
        end
        chk("ovf_frames", 32'(cnt), 32'd4);
        chk("ovf_drain_busy", 32'(busy0), 32'd0);
        chk("ovf_drain_lvl",  32'(lvl0),  32'd0);

`ifdef UART_TX_PARITY_EN
        // Even parity, mode switched to odd mid-frame has no effect.
        pm0 = 2'b01;
        wr0 = 1'b1; wd0 = 8'h07;
        @(negedge clk);
        wr0 = 1'b0;
        @(negedge clk);
        pm0 = 2'b10;
        @(negedge clk);
        check_frame(1'b0, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, "par_e");
        @(negedge clk);
        wr0 = 1'b1; wd0 = 8'h07;
        @(negedge clk);
        wr0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_frame(1'b0, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, "par_o");
        pm0 = 2'b00;
        @(negedge clk);
`endif

        // 5 data bits, 2 stop bits.
        wr1 = 1'b1; wd1 = 5'h1F;
        @(negedge clk);
        wr1 = 1'b0;
        chk("w5_lvl", 32'(lvl1), 32'd1);
        @(negedge clk);
        chk("w5_busy", 32'(busy1), 32'd1);
        @(negedge clk);
        check_frame(1'b1, 12'h0FE, 8, "w5s2");
        @(negedge clk);
        chk("w5_end_busy", 32'(busy1), 32'd0);
        chk("w5_end_txp",  32'(tx1),   32'd1);

        // Reset in the middle of a data bit abandons everything.
        wr0 = 1'b1; wd0 = 8'h5A;
        @(negedge clk);
        wd0 = 8'h3C;
        @(negedge clk);
        wr0 = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_busy", 32'(busy0), 32'd1);
        chk("mid_lvl",  32'(lvl0),  32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_txp",   32'(tx0),   32'd1);
        chk("mrst_busy",  32'(busy0), 32'd0);
        chk("mrst_lvl",   32'(lvl0),  32'd0);
        chk("mrst_ready", 32'(rdy0),  32'd1);
        chk("mrst_done",  32'(done0), 32'd0);
        cnt = 0;
        lows = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done0) cnt++;
            if (!tx0) lows++;
        end
        chk("mrst_no_done", 32'(cnt),  32'd0);
        chk("mrst_no_low",  32'(lows), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Parametrised, FIFO-buffered UART transmitter, next generation of the single-width 8N1 FIFO transmitter. Accepts words on a valid/ready write port, buffers them in an internal synchronous FIFO, and serialises them LSB-first with configurable data width, stop bits and optional parity. Back-to-back frames are sent with no idle gap. Sits between on-chip producers (SPI bridge, debug logger) and the board TX pin.

## Interface
- CLK_DIV, 5: clk cycles per bit; ≥2.
- DATA_BITS, 8: data bits per frame; 5..8.
- FIFO_DEPTH, 128: FIFO words; power of two, ≥2.
- STOP_BITS, 1: stop bits per frame; 1 or 2.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- wr_en  in  1  write strobe; word accepted when wr_en && ready.
- wr_data  in  DATA_BITS  word to send.
- ready  out  1  FIFO not full; reset 1.
- overflow  out  1  one-cycle pulse when wr_en && !ready (word dropped); reset 0.
- level  out  $clog2(FIFO_DEPTH)+1  words held in FIFO (excludes word in shifter); reset 0.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none; present only with UART_TX_PARITY_EN.
- busy  out  1  frame in progress; reset 0.
- o_txp  out  1  serial line, idle high; reset 1.
- tx_done  out  1  one-cycle pulse at end of each frame's last stop bit; reset 0.

## Operation
- FIFO: extra-MSB pointer scheme; full = MSBs differ, low bits equal; empty = pointers equal. Write when full ignored, pointer unchanged, overflow pulses. Write when full with simultaneous pop still rejected (ready is pre-edge state).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO non-empty, pop head into shifter, latch parity_mode, go START.
  - START: o_txp=0 for CLK_DIV cycles -> DATA.
  - DATA: bit i (LSB first) for CLK_DIV cycles each; after bit DATA_BITS-1 -> PARITY if parity enabled and latched mode 01/10, else STOP.
  - PARITY: o_txp = XOR(data) for even, ~XOR(data) for odd; CLK_DIV cycles -> STOP.
  - STOP: o_txp=1 for STOP_BITS*CLK_DIV cycles; at final cycle pulse tx_done; if FIFO non-empty pop and go START directly (no idle cycle), else IDLE.
- Bit counter width $clog2(DATA_BITS); baud counter width $clog2(CLK_DIV); counter wraps to 0 at CLK_DIV-1.
- parity_mode changes mid-frame have no effect on current frame.
- level increments on accepted write, decrements on pop, unchanged on both same cycle.
- busy high in START/DATA/PARITY/STOP.
- Reset mid-frame: next cycle o_txp=1, FIFO emptied, all outputs at reset values; partial frame abandoned.

## Timing
- Write accepted at edge E0 into empty FIFO with FSM IDLE: level=1 after E0; pop at E1 (level=0, busy=1, FSM START); o_txp low from E2 (o_txp registered from state).
- Each bit occupies exactly CLK_DIV cycles on o_txp.
- Frame length = (1 + DATA_BITS + P + STOP_BITS) × CLK_DIV cycles, P=1 with parity active.
- Back-to-back: next start bit's low follows last stop cycle immediately; o_txp gap is exactly the stop bits.
- tx_done asserted one cycle, coinciding with the last cycle of the stop period as seen on o_txp.

## Configuration
- UART_TX_PARITY_EN defined: parity_mode port present, PARITY state implemented as above.
- Undefined: no parity_mode port, PARITY state absent, frames always DATA_BITS-N-STOP_BITS.

## Test plan
- CLK_DIV=4, DATA_BITS=8, write 0xA5 -> o_txp: 0, 1,0,1,0,0,1,0,1, 1, each 4 cycles; tx_done one pulse; start low at E2.
- Write 0x01,0x02,0x03 consecutive cycles -> three frames, no idle between stop and next start, level 2,1,0 peak-down, three tx_done pulses.
- FIFO_DEPTH=4, write 6 words while TX busy -> 4 queued+1 in shifter accepted as space allows, ready low at full, overflow pulses for each dropped word.
- UART_TX_PARITY_EN, parity_mode=01 with 0x07 -> parity bit 1; mode=10 with 0x07 -> 0; mode changed mid-frame -> current frame unaffected.
- DATA_BITS=5, STOP_BITS=2, write 0x1F -> start, five 1s, stop high 2×CLK_DIV, frame 8×CLK_DIV cycles.
- rst_n low during DATA -> o_txp=1, busy=0, level=0, ready=1 next cycle; no tx_done.
